// File: rtl/memoria_frota.sv
// Per-player fleet memory: placement writes, registered reads, and an atomic
// hit read-modify-write that clears the struck slot and tracks sunk ships.
module memoria_frota #(
  parameter int DEPTH  = 12,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 65
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              hit_req,
  input  logic [ADDR_W-1:0] hit_addr,
  input  logic [7:0]        hit_coord,
  output logic              busy,
  output logic              ack,
  output logic              hit_ok,
  output logic              sunk,
  output logic [3:0]        sunk_count,
  output logic              fleet_down
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam int SLOTS    = 5;
  localparam int SLOT_LSB = 3;
  localparam int PCS_LSB  = 45;

  typedef enum logic [1:0] {IDLE, CHECK, UPDATE} state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          coord_q;
  logic                match_q;
  logic [2:0]          slot_q;

  logic                load_ok;
  logic                hit_accept;
  logic [DATA_W-1:0]   chk_rec;
  logic [DATA_W-1:0]   upd_rec;
  logic [2:0]          pieces;
  logic                match_c;
  logic [2:0]          slot_c;
  logic                sunk_nx;
  logic                any_ship;
  logic                all_empty;

  // A load in IDLE always takes priority over a simultaneous hit request.
  assign load_ok    = load_en && (state == IDLE) && (load_addr < DEPTH_A);
  assign hit_accept = hit_req && !load_en && (state == IDLE);
  assign busy       = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    chk_rec = '0;
    if (addr_q < DEPTH_A) chk_rec = mem[addr_q[IDX_W-1:0]];
  end

  // Descending scan so the lowest-index matching slot is the one kept.
  always_comb begin
    match_c = 1'b0;
    slot_c  = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (coord_q != 8'h00 && chk_rec[2:0] != 3'd0 &&
          chk_rec[SLOT_LSB + 8*i +: 8] == coord_q) begin
        match_c = 1'b1;
        slot_c  = 3'(i);
      end
    end
  end

  always_comb begin
    pieces  = chk_rec[PCS_LSB +: 3];
    upd_rec = chk_rec;
    for (int i = 0; i < SLOTS; i++) begin
      if (slot_q == 3'(i)) upd_rec[SLOT_LSB + 8*i +: 8] = 8'h00;
    end
    upd_rec[PCS_LSB +: 3] = (pieces == 3'd0) ? 3'd0 : pieces - 3'd1;
    sunk_nx = match_q && (pieces == 3'd1);
  end

  always_comb begin
    any_ship  = 1'b0;
    all_empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i][2:0] != 3'd0) begin
        any_ship = 1'b1;
        if (mem[i][PCS_LSB +: 3] != 3'd0) all_empty = 1'b0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hit_accept) state_nx = CHECK;
      CHECK:   state_nx = UPDATE;
      UPDATE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      coord_q    <= '0;
      match_q    <= 1'b0;
      slot_q     <= '0;
      ack        <= 1'b0;
      hit_ok     <= 1'b0;
      sunk       <= 1'b0;
      sunk_count <= '0;
      fleet_down <= 1'b0;
      rd_data    <= '0;
    end else begin
      state      <= state_nx;
      ack        <= (state == UPDATE);
      hit_ok     <= (state == UPDATE) && match_q;
      sunk       <= (state == UPDATE) && sunk_nx;
      fleet_down <= any_ship && all_empty;
      rd_data    <= (rd_addr < DEPTH_A) ? mem[rd_addr[IDX_W-1:0]] : '0;
      if (hit_accept) begin
        addr_q  <= hit_addr;
        coord_q <= hit_coord;
      end
      if (state == CHECK) begin
        match_q <= match_c;
        slot_q  <= slot_c;
      end
      if (state == UPDATE && sunk_nx && sunk_count != 4'hF)
        sunk_count <= sunk_count + 4'd1;
    end
  end

  // NOTE: the record array is reset explicitly because an empty fleet after
  // reset is observable behaviour, so it must live in resettable flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (load_ok) begin
      mem[load_addr[IDX_W-1:0]] <= load_data;
    end else if (state == UPDATE && match_q) begin
      mem[addr_q[IDX_W-1:0]] <= upd_rec;
    end
  end

endmodule

// File: tb/tb_memoria_frota.sv
// Self-checking bench for memoria_frota: directed scenarios followed by
// randomized loads, hits and reads against a transaction-level fleet model.
module tb_memoria_frota;

  localparam int DEPTH  = 12;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 65;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              hit_req;
  logic [ADDR_W-1:0] hit_addr;
  logic [7:0]        hit_coord;
  logic              busy;
  logic              ack;
  logic              hit_ok;
  logic              sunk;
  logic [3:0]        sunk_count;
  logic              fleet_down;

  int checks = 0;
  int errors = 0;

  // Reference model: the fleet as plain records plus the sunk tally.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                ref_sunk;

  logic [7:0] pool [6] = '{8'h00, 8'h11, 8'h12, 8'h21, 8'h22, 8'h33};

  memoria_frota #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .hit_req(hit_req), .hit_addr(hit_addr), .hit_coord(hit_coord),
    .busy(busy), .ack(ack), .hit_ok(hit_ok), .sunk(sunk),
    .sunk_count(sunk_count), .fleet_down(fleet_down)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_rec(input int tipo, input int pcs,
      input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
      input logic [7:0] s3, input logic [7:0] s4);
    logic [DATA_W-1:0] r;
    r = '0;
    r[2:0]   = 3'(tipo);
    r[10:3]  = s0;
    r[18:11] = s1;
    r[26:19] = s2;
    r[34:27] = s3;
    r[42:35] = s4;
    r[47:45] = 3'(pcs);
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_sunk = 0;
  endfunction

  // Shot at one record: first slot holding the coordinate is erased.
  function automatic void model_hit(input int a, input logic [7:0] c,
                                    output bit ok, output bit snk);
    int p;
    ok  = 0;
    snk = 0;
    if (a >= DEPTH || c == 8'h00 || ref_mem[a][2:0] == 3'd0) return;
    for (int s = 0; s < 5; s++) begin
      if (ref_mem[a][3 + 8*s +: 8] == c) begin
        ok = 1;
        ref_mem[a][3 + 8*s +: 8] = 8'h00;
        p = int'(ref_mem[a][47:45]);
        if (p > 0) ref_mem[a][47:45] = 3'(p - 1);
        if (p == 1) begin
          snk = 1;
          if (ref_sunk < 15) ref_sunk++;
        end
        return;
      end
    end
  endfunction

  function automatic bit model_fleet_down();
    int ships = 0;
    int alive = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ref_mem[i][2:0] != 3'd0) begin
        ships++;
        if (ref_mem[i][47:45] != 3'd0) alive++;
      end
    end
    return (ships > 0) && (alive == 0);
  endfunction

  // All tasks start and end on a falling edge with the DUT idle.
  task automatic do_load(input int a, input logic [DATA_W-1:0] d);
    load_en   = 1'b1;
    load_addr = ADDR_W'(a);
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    if (a < DEPTH) ref_mem[a] = d;
  endtask

  task automatic do_read(input int a);
    logic [DATA_W-1:0] exp;
    rd_addr = ADDR_W'(a);
    @(negedge clk);
    exp = (a < DEPTH) ? ref_mem[a] : '0;
    check("rd_data", rd_data, exp);
    check("fleet_down", 65'(fleet_down), 65'(model_fleet_down()));
  endtask

  task automatic wait_ack(output int lat);
    lat = 1;
    while (!ack && lat < 8) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_hit(input int a, input logic [7:0] c);
    bit eok, esnk;
    int lat;
    model_hit(a, c, eok, esnk);
    hit_addr  = ADDR_W'(a);
    hit_coord = c;
    hit_req   = 1'b1;
    @(negedge clk);
    hit_req = 1'b0;
    check("busy_after_accept", 65'(busy), 65'(1));
    wait_ack(lat);
    check("ack_latency", 65'(lat), 65'(3));
    check("hit_ok", 65'(hit_ok), 65'(eok));
    check("sunk", 65'(sunk), 65'(esnk));
    check("sunk_count", 65'(sunk_count), 65'(ref_sunk));
    check("busy_at_ack", 65'(busy), 65'(0));
  endtask

  initial begin
    int lat;
    bit eok, esnk;
    logic [DATA_W-1:0] rec;

    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    rd_addr = '0; hit_req = 1'b0; hit_addr = '0; hit_coord = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_busy", 65'(busy), 65'(0));
    check("rst_ack", 65'(ack), 65'(0));
    check("rst_sunk_count", 65'(sunk_count), 65'(0));
    check("rst_fleet_down", 65'(fleet_down), 65'(0));
    check("rst_rd_data", rd_data, 65'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Two-piece ship at address 3.
    do_load(3, mk_rec(3, 2, 8'h21, 8'h22, 8'h00, 8'h00, 8'h00));
    do_read(3);
    do_hit(3, 8'h22);
    do_read(3);
    check("rec3_after_first_hit", rd_data, 65'(mk_rec(3, 1, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00)));
    do_hit(3, 8'h21);
    check("sunk_count_one", 65'(sunk_count), 65'(1));
    do_read(3);
    check("fleet_down_single", 65'(fleet_down), 65'(1));
    do_hit(3, 8'h21);
    do_read(3);
    do_hit(13, 8'h21);
    do_hit(3, 8'h00);
    do_read(3);

    // Ship at 5, then hit_req during CHECK and load_en during UPDATE.
    do_load(5, mk_rec(2, 2, 8'h33, 8'h12, 8'h00, 8'h00, 8'h00));
    model_hit(5, 8'h12, eok, esnk);
    hit_addr = 5'd5; hit_coord = 8'h12; hit_req = 1'b1;
    @(negedge clk);
    hit_addr = 5'd5; hit_coord = 8'h33;
    @(negedge clk);
    hit_req = 1'b0;
    load_en = 1'b1; load_addr = 5'd5; load_data = mk_rec(7, 5, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    load_en = 1'b0;
    check("ign_ack", 65'(ack), 65'(1));
    check("ign_hit_ok", 65'(hit_ok), 65'(eok));
    @(negedge clk);
    check("ign_no_second_ack", 65'(ack), 65'(0));
    check("ign_idle", 65'(busy), 65'(0));
    do_read(5);

    // Load and hit in the same idle cycle: load wins, no request starts.
    load_en = 1'b1; load_addr = 5'd4; load_data = mk_rec(1, 1, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00);
    hit_req = 1'b1; hit_addr = 5'd5; hit_coord = 8'h33;
    @(negedge clk);
    load_en = 1'b0; hit_req = 1'b0;
    ref_mem[4] = mk_rec(1, 1, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00);
    check("collide_not_busy", 65'(busy), 65'(0));
    wait_ack(lat);
    check("collide_no_ack", 65'(lat), 65'(8));
    do_read(4);
    do_read(5);

    // Reload of the sunk ship keeps the tally; fleet is not down.
    do_load(3, mk_rec(3, 1, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00));
    do_read(3);
    check("reload_keeps_sunk", 65'(sunk_count), 65'(1));

    // Reset during CHECK aborts the request.
    hit_addr = 5'd3; hit_coord = 8'h21; hit_req = 1'b1;
    @(negedge clk);
    hit_req = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_busy", 65'(busy), 65'(0));
    check("mid_rst_sunk_count", 65'(sunk_count), 65'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack(lat);
    check("mid_rst_no_ack", 65'(lat), 65'(8));
    do_read(3);
    do_hit(3, 8'h21);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 3) begin
        rec = mk_rec(int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
                     pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)],
                     pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)],
                     pool[$urandom_range(0, 5)]);
        do_load(int'($urandom_range(0, 15)), rec);
      end else if (op < 8) begin
        do_hit(int'($urandom_range(0, 15)), pool[$urandom_range(0, 5)]);
      end else begin
        do_read(int'($urandom_range(0, 15)));
      end
    end
    for (int i = 0; i < DEPTH; i++) do_read(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memoria_frota.md
Name: memoria_frota

Overview:
- Per-player fleet memory. It is the responder end of the collision checker's read/clear interface.
- Holds DEPTH ship records written during placement.
- Serves records by address with one-cycle read latency.
- Executes hit requests as an atomic read-modify-write: clear the struck coordinate, decrement the pieces-remaining count, report sunk ships and fleet destruction.
- One instance per player, between the placement logic and the collision checker.

Parameters:
DEPTH, 12, number of ship records
ADDR_W, 5, address width
DATA_W, 65, record width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load_en  in  1  placement write strobe
load_addr  in  ADDR_W  placement record address
load_data  in  DATA_W  placement record
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  registered read data
hit_req  in  1  hit request strobe, accepted only when busy=0
hit_addr  in  ADDR_W  record to test
hit_coord  in  8  shot coordinate {y[3:0],x[3:0]}
busy  out  1  hit request in progress
ack  out  1  one-cycle pulse, hit request completed
hit_ok  out  1  valid with ack: 1 = coordinate found and cleared
sunk  out  1  one-cycle pulse with ack when a ship's pieces reach 0
sunk_count  out  4  ships sunk since reset
fleet_down  out  1  every loaded ship has 0 pieces

Behaviour:
- Record format:
  - [2:0] tipo; 0 = empty entry.
  - Slots s0..s4 at [10:3], [18:11], [26:19], [34:27], [42:35].
  - [44:43] reserved, 0.
  - [47:45] pieces remaining.
  - [64:48] zero.
- Coordinate 8'h00 is the empty/cleared slot marker and never matches. Board coordinates with x=0 and y=0 together are illegal.
- Reset: all records 0; rd_data=0, busy=0, ack=0, hit_ok=0, sunk=0, sunk_count=0, fleet_down=0, FSM in IDLE. Asserting reset mid-request aborts it with no ack.
- Read: rd_data <= mem[rd_addr] every cycle. rd_addr >= DEPTH returns 0. Reads return the committed contents; a write made in cycle n is visible in rd_data from cycle n+2.
- Load: when load_en=1, load_addr < DEPTH and state=IDLE, the record is written at the clock edge.
  - Out-of-range address: ignored.
  - load_en while busy=1: ignored.
  - load_en and hit_req in the same IDLE cycle: the load wins and hit_req is ignored.
- FSM:
  - IDLE: on hit_req with busy=0, latch hit_addr and hit_coord, go to CHECK, busy=1.
  - CHECK: compare the latched coordinate against s0..s4 of the record.
    - Select the lowest-index matching slot.
    - hit_addr >= DEPTH, or tipo=0 → no match.
    - Go to UPDATE.
  - UPDATE, match: write the slot to 8'h00 and set pieces = pieces-1 (saturating at 0); ack=1, hit_ok=1.
    - If pieces goes 1→0: sunk=1 and sunk_count+1 (saturating at 15).
  - UPDATE, no match: ack=1, hit_ok=0, memory unchanged. Next state IDLE, busy=0.
- Latency: accept at edge n, ack high during cycle n+2. A new hit_req may be accepted the cycle ack is high. Minimum spacing between accepts is 3 cycles.
- hit_req while busy=1 is ignored. The requester waits for busy=0.
- Repeat shot on an already-cleared coordinate: hit_ok=0, and pieces is not decremented.
- fleet_down: registered, re-evaluated every cycle. It is 1 iff at least one record has tipo≠0 and all such records have pieces=0. Reloading a ship with pieces>0 drops it the next cycle.
- sunk_count is not reduced by reloads; only reset clears it.

Test Plan:
- Load addr 3 = {pieces=2, s0=8'h21, s1=8'h22, tipo=3}; hit_req addr 3 coord 8'h22 → ack at n+2, hit_ok=1, sunk=0. A following read of addr 3 shows s1=00 and pieces=1.
- Same record, then hit 8'h21 → hit_ok=1, sunk pulse, sunk_count=1. fleet_down=1 when this is the only loaded ship.
- Repeat hit 8'h21 → hit_ok=0, pieces stays 0, sunk_count stays 1.
- hit_addr=13 or hit_coord=8'h00 → ack with hit_ok=0, memory unchanged.
- hit_req asserted during CHECK, and load_en during UPDATE → both ignored, memory and ack sequence unaffected.
- rst_n low during CHECK → no ack; all records and outputs 0; the next hit on the previous coordinate returns hit_ok=0.
